serial_link: RTL and testbench
==============================

Name: serial_link

Overview:
- Point-to-point serial transfer block: a sender and a receiver running from one clock.
- The sender captures a 7-bit parallel word and shifts it out one bit per cycle on `data_line`, with `strobe` qualifying each bit.
- The receiver deserializes the bits and presents the reassembled word on `data_out`.
- Used as a minimal on-chip serial channel. One word is sent per reset release.

Parameters:
- WIDTH, 7, number of data bits per word (sender shift count and receiver bit count).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset for both sender and receiver.
- data_in  input  WIDTH  parallel word to send; index 1 is the MSB and index WIDTH is the LSB (declared [1:WIDTH]).
- data_out  output  WIDTH  last fully received word, declared [1:WIDTH].
- data_line  output  1  serial data, registered in the sender.
- strobe  output  1  high while data_line carries a valid bit, registered in the sender.
- tx_done  output  1  high once the sender has emitted all WIDTH bits.
- rx_valid  output  1  one-cycle pulse on the edge that updates data_out.

Behaviour:
- Reset (rst=1 at a rising edge) puts both halves in a known state:
  - sender state IDLE; data_line=0, strobe=0, tx_done=0;
  - receiver bit counter=0, shift register=0; data_out=0, rx_valid=0.
- Reset overrides everything, including mid-transfer. Any partial word is discarded and data_out returns to 0.
- Sender FSM has three states: IDLE, SEND, DONE.
  - IDLE: at the first rising edge with rst=0, latch data_in into the tx shift register. Drive data_line=data_in[1] and strobe=1, then go to SEND. data_in is sampled only on this edge; later changes are ignored.
  - SEND: on each edge, advance to the next bit in order data_in[1] to data_in[WIDTH], one bit per cycle. strobe stays 1 for exactly WIDTH consecutive cycles.
  - Leaving SEND: on the edge after the cycle carrying bit WIDTH, go to DONE with strobe=0, data_line=0, tx_done=1.
  - DONE: terminal state. Hold the DONE outputs until rst; no further transfer without a reset.
- Receiver:
  - On each rising edge with strobe=1, shift data_line into the rx shift register: left shift, new bit enters at index WIDTH, so the first bit ends at index 1. Increment the bit counter.
  - Capture: on the edge that captures bit number WIDTH, load data_out with the complete word (including that bit) in the same edge. Pulse rx_valid for that cycle and clear the counter.
  - strobe=0: no shift, counter holds, data_out holds.
- Timing, with E1 = first edge where rst=0:
  - bits k=1..WIDTH are on the line after edge Ek;
  - the receiver samples bit k at edge E(k+1);
  - data_out is valid after E(WIDTH+1), i.e. 8 edges after reset release for WIDTH=7;
  - tx_done rises at the same edge.
- data_out equals data_in as latched at E1, bit for bit.
- No parity, no framing bits, no backpressure.

Test Plan:
- Reset: hold rst=1 for two edges -> data_out=0, strobe=0, data_line=0, tx_done=0, rx_valid=0.
- Basic transfer: release rst with data_in=1010111, run 10 cycles.
  - data_line serial sequence is 1,0,1,0,1,1,1 with strobe high for exactly 7 cycles.
  - data_out=1010111 after the 8th edge; rx_valid pulses once; tx_done=1 and stays.
- Second transfer after reset: assert rst for one edge -> data_out=0. Release with data_in=0010101 and run 10 cycles -> data_out=0010101.
- data_in change mid-transfer: latch 1111111, change data_in to 0000000 at edge 3 -> data_out=1111111.
- Reset mid-transfer: assert rst at edge 4 of a 1010111 transfer.
  - Required: strobe=0 and data_out=0 immediately.
  - Release with data_in=0110011 -> data_out=0110011 after 8 edges, no stale bits.
- DONE hold: after a transfer, run 20 more cycles with rst=0 -> strobe stays 0, data_out unchanged, no further rx_valid pulses.

Source files
------------

// File: rtl/serial_link.sv
// Purpose: point-to-point serial channel; sender shifts a WIDTH-bit word MSB (index 1) first, receiver reassembles it.
// Latency: data_out/rx_valid and tx_done update WIDTH+1 edges after reset release (bit k on the line after edge k).
// Backpressure: none; strobe qualifies every bit and one word is sent per reset release.
module serial_link #(
    parameter int WIDTH = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:WIDTH] data_in,
    output logic [1:WIDTH] data_out,
    output logic           data_line,
    output logic           strobe,
    output logic           tx_done,
    output logic           rx_valid
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_e;

    // Sender state
    tx_state_e      state_q, state_d;
    logic [1:WIDTH] tx_sr_q, tx_sr_d;
    logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
    logic           data_line_q, data_line_d;
    logic           strobe_q, strobe_d;
    logic           tx_done_q, tx_done_d;

    // Receiver state
    logic [1:WIDTH] rx_sr_q, rx_sr_d;
    logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
    logic [1:WIDTH] data_out_q, data_out_d;
    logic           rx_valid_q, rx_valid_d;

    // Sender next state: IDLE latches the word and puts bit 1 out, SEND walks the rest, DONE parks
    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        tx_cnt_d    = tx_cnt_q;
        data_line_d = data_line_q;
        strobe_d    = strobe_q;
        tx_done_d   = tx_done_q;
        case (state_q)
            IDLE: begin
                // tx_sr holds the bits not yet driven, left-aligned at index 1
                data_line_d = data_in[1];
                strobe_d    = 1'b1;
                tx_sr_d     = {data_in[2:WIDTH], 1'b0};
                tx_cnt_d    = CW'(1);
                state_d     = SEND;
            end
            SEND: begin
                if (tx_cnt_q == CW'(WIDTH)) begin
                    data_line_d = 1'b0;
                    strobe_d    = 1'b0;
                    tx_done_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    data_line_d = tx_sr_q[1];
                    tx_sr_d     = {tx_sr_q[2:WIDTH], 1'b0};
                    tx_cnt_d    = tx_cnt_q + CW'(1);
                end
            end
            DONE: begin
                data_line_d = 1'b0;
                strobe_d    = 1'b0;
                tx_done_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Receiver next state: shift on strobe, publish the word on the edge that takes the last bit
    always_comb begin
        rx_sr_d    = rx_sr_q;
        rx_cnt_d   = rx_cnt_q;
        data_out_d = data_out_q;
        rx_valid_d = 1'b0;
        if (strobe_q) begin
            rx_sr_d = {rx_sr_q[2:WIDTH], data_line_q};
            if (rx_cnt_q == CW'(WIDTH - 1)) begin
                data_out_d = rx_sr_d;
                rx_valid_d = 1'b1;
                rx_cnt_d   = '0;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
        end
    end

    // State registers for both halves; reset discards any partial word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_sr_q     <= '0;
            tx_cnt_q    <= '0;
            data_line_q <= 1'b0;
            strobe_q    <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_sr_q     <= '0;
            rx_cnt_q    <= '0;
            data_out_q  <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            tx_cnt_q    <= tx_cnt_d;
            data_line_q <= data_line_d;
            strobe_q    <= strobe_d;
            tx_done_q   <= tx_done_d;
            rx_sr_q     <= rx_sr_d;
            rx_cnt_q    <= rx_cnt_d;
            data_out_q  <= data_out_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign data_out  = data_out_q;
    assign data_line = data_line_q;
    assign strobe    = strobe_q;
    assign tx_done   = tx_done_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_serial_link.sv
module tb_serial_link;

    localparam int WIDTH = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:WIDTH] data_in = '0;
    logic [1:WIDTH] data_out;
    logic           data_line;
    logic           strobe;
    logic           tx_done;
    logic           rx_valid;

    int total = 0;
    int bad   = 0;

    logic [1:WIDTH] exp_q[$];

    typedef struct {
        logic [1:WIDTH] din;
        logic [1:WIDTH] alt;
        int             chg_edge;
    } vec_t;

    vec_t vecs[4];

    serial_link #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .data_line(data_line),
        .strobe   (strobe),
        .tx_done  (tx_done),
        .rx_valid (rx_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        chk({tag, " data_out"},  32'(data_out),  32'd0);
        chk({tag, " strobe"},    32'(strobe),    32'd0);
        chk({tag, " data_line"}, 32'(data_line), 32'd0);
        chk({tag, " tx_done"},   32'(tx_done),   32'd0);
        chk({tag, " rx_valid"},  32'(rx_valid),  32'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        check_idle_reset("reset");
    endtask

    // Release reset with din and watch ncycles edges; data_in may change to alt after edge chg_edge
    task automatic transfer(input logic [1:WIDTH] din, input logic [1:WIDTH] alt,
                            input int chg_edge, input int ncycles);
        int pulses;
        logic [1:WIDTH] exp_word;
        pulses  = 0;
        data_in = din;
        rst     = 1'b0;
        exp_q.push_back(din);
        for (int e = 1; e <= ncycles; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("strobe e%0d", e), 32'(strobe), 32'(e <= WIDTH));
            if (e <= WIDTH)
                chk($sformatf("data_line e%0d", e), 32'(data_line), 32'(din[e]));
            chk($sformatf("tx_done e%0d", e), 32'(tx_done), 32'(e > WIDTH));
            if (e <= WIDTH)
                chk($sformatf("data_out early e%0d", e), 32'(data_out), 32'd0);
            if (rx_valid) begin
                pulses++;
                chk("rx_valid edge", 32'(e), 32'(WIDTH + 1));
                if (exp_q.size() == 0) begin
                    chk("scoreboard empty on rx_valid", 32'd1, 32'd0);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("data_out word", 32'(data_out), 32'(exp_word));
                end
            end
            if (e == chg_edge) data_in = alt;
        end
        chk("rx_valid pulses", 32'(pulses), 32'd1);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vecs[0] = '{din: 7'b1010111, alt: 7'b1010111, chg_edge: 0};
        vecs[1] = '{din: 7'b0010101, alt: 7'b0010101, chg_edge: 0};
        vecs[2] = '{din: 7'b1111111, alt: 7'b0000000, chg_edge: 3};
        vecs[3] = '{din: 7'b0000001, alt: 7'b1111110, chg_edge: 1};

        // Reset held for two edges, then table of transfers each preceded by a one-edge reset
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) do_reset(1);
            transfer(vecs[i].din, vecs[i].alt, vecs[i].chg_edge, 10);
        end

        // DONE hold: 20 more idle cycles after the last transfer
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("hold strobe",   32'(strobe),   32'd0);
            chk("hold rx_valid", 32'(rx_valid), 32'd0);
            chk("hold tx_done",  32'(tx_done),  32'd1);
            chk("hold data_out", 32'(data_out), 32'(7'b0000001));
        end

        // Reset mid-transfer: three clean edges, reset lands on edge 4
        do_reset(1);
        data_in = 7'b1010111;
        rst     = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            chk("partial rx_valid", 32'(rx_valid), 32'd0);
            chk("partial strobe", 32'(strobe), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_reset("mid reset");
        transfer(7'b0110011, 7'b0110011, 0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past limit, expected completion");
        $fatal(1);
    end

endmodule
